// File: rtl/simon_seq_engine_pkg.sv
// Shared types for the Simon sequence engine: colour type, FSM states and the
// 8-bit to 2-bit entropy fold.
package simon_seq_engine_pkg;

    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_IN,
        S_PASS,
        S_FAIL
    } state_t;

    function automatic color_t fold_color(input logic [7:0] rnd);
        return rnd[1:0] ^ rnd[3:2] ^ rnd[5:4] ^ rnd[7:6];
    endfunction

endpackage

// File: rtl/simon_seq_engine_if.sv
// Control/status bundle between a game controller (master) and the sequence
// engine (slave).
interface simon_seq_engine_if #(
    parameter int DEPTH = 32
) ();
    import simon_seq_engine_pkg::*;

    logic                   clear;
    logic [7:0]             rnd;
    logic                   add_step;
    logic                   start_play;
    logic                   btn_valid;
    color_t                 btn_color;
    logic                   led_on;
    color_t                 led_color;
    logic                   busy;
    logic [$clog2(DEPTH):0] seq_len;
    logic                   full;
    logic                   round_pass;
    logic                   round_fail;

    modport master (
        output clear, rnd, add_step, start_play, btn_valid, btn_color,
        input  led_on, led_color, busy, seq_len, full, round_pass, round_fail
    );

    modport slave (
        input  clear, rnd, add_step, start_play, btn_valid, btn_color,
        output led_on, led_color, busy, seq_len, full, round_pass, round_fail
    );

endinterface

// File: rtl/simon_seq_engine_phase_timer.sv
// Loadable down-counter shared by the show-on, show-off and input-timeout phases.
// done is high while the count sits at zero; the counter parks there.
module simon_seq_engine_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/simon_seq_engine.sv
// Simon sequence engine: records folded counter samples, replays them on the
// LED and checks the player's presses against the stored sequence.
//
// state      | meaning
// S_IDLE     | accept add_step / start_play
// S_SHOW_ON  | LED lit with mem[idx]
// S_SHOW_OFF | dark gap after each colour
// S_WAIT_IN  | waiting for press idx, timeout running
// S_PASS     | one-cycle round_pass
// S_FAIL     | one-cycle round_fail
module simon_seq_engine
    import simon_seq_engine_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input logic              clk,
    input logic              rst,
    simon_seq_engine_if.slave bus
);

    localparam int IW    = $clog2(DEPTH);
    localparam int LW    = IW + 1;
    localparam int T_MAX = (ON_CYCLES > OFF_CYCLES)
                         ? ((ON_CYCLES > TIMEOUT) ? ON_CYCLES : TIMEOUT)
                         : ((OFF_CYCLES > TIMEOUT) ? OFF_CYCLES : TIMEOUT);
    localparam int TW    = $clog2(T_MAX + 1);

    // Phases last load value + 1 cycles since done is checked at zero.
    localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [LW-1:0]   seq_len;
    color_t          mem [DEPTH];
    color_t          cur;
    logic            wr_en;
    logic            last;
    logic            full;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_done;

    simon_seq_engine_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign cur  = mem[idx];
    assign last = ({1'b0, idx} == (seq_len - 1'b1));
    assign full = (seq_len == LW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            seq_len <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (bus.clear) begin
                seq_len <= '0;
            end else if (wr_en) begin
                seq_len <= seq_len + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[seq_len[IW-1:0]] <= fold_color(bus.rnd);
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_en     = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (bus.clear) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            tmr_load  = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.add_step) begin
                        wr_en = !full;
                    end else if (bus.start_play && seq_len != '0) begin
                        state_nxt = S_SHOW_ON;
                        idx_nxt   = '0;
                        tmr_load  = 1'b1;
                        tmr_val   = ON_LD;
                    end
                end
                S_SHOW_ON: begin
                    if (tmr_done) begin
                        state_nxt = S_SHOW_OFF;
                        tmr_load  = 1'b1;
                        tmr_val   = OFF_LD;
                    end
                end
                S_SHOW_OFF: begin
                    if (tmr_done) begin
                        tmr_load = 1'b1;
                        if (last) begin
                            state_nxt = S_WAIT_IN;
                            idx_nxt   = '0;
                            tmr_val   = TO_LD;
                        end else begin
                            state_nxt = S_SHOW_ON;
                            idx_nxt   = idx + 1'b1;
                            tmr_val   = ON_LD;
                        end
                    end
                end
                S_WAIT_IN: begin
                    // A press in the expiry cycle is judged, not timed out.
                    if (bus.btn_valid) begin
                        tmr_load = 1'b1;
                        tmr_val  = TO_LD;
                        if (bus.btn_color != cur) begin
                            state_nxt = S_FAIL;
                        end else if (last) begin
                            state_nxt = S_PASS;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else if (tmr_done) begin
                        state_nxt = S_FAIL;
                    end
                end
                S_PASS, S_FAIL: begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.led_on     = (state == S_SHOW_ON);
    assign bus.led_color  = (state == S_SHOW_ON) ? cur : 2'b00;
    assign bus.busy       = (state != S_IDLE);
    assign bus.seq_len    = seq_len;
    assign bus.full       = full;
    assign bus.round_pass = (state == S_PASS);
    assign bus.round_fail = (state == S_FAIL);

endmodule
